// File: rtl/core_pkg.sv
// Shared constants, enums and decode helpers for the multicycle MIPS-subset core.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  function automatic logic instr_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default:                               ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Non-R-type instructions all use the adder (addi, lw/sw address).
  function automatic alu_op_e alu_op_of(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_e op;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_SLT:  op = ALU_SLT;
        default: op = ALU_ADD;
      endcase
    end else begin
      op = ALU_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear, register 0 hardwired to zero.
module regfile_2r1w #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_r [NREG];

  // Register storage; writes to register 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == {AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr1];
  assign rdata2 = (raddr2 == {AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB with one shared ALU and
// request/valid handshakes to instruction and data memories of any latency.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 6,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_valid,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  localparam int REG_AW = $clog2(NREG);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e            state_r, state_next_s;
  logic [31:0]       ir_r;
  logic [PC_W-1:0]   pc_r;
  logic [DATA_W-1:0] a_r, b_r, imm_r, alu_r, mdr_r;
  logic              imem_req_r, dmem_req_r, dmem_we_r, halted_r;
  logic [PC_W-1:0]   dmem_addr_r;
  logic [DATA_W-1:0] dmem_wdata_r;

  logic [5:0]        op_s, funct_s;
  logic              legal_s, imem_fire_s, dmem_fire_s, retire_s;
  logic [DATA_W-1:0] rd1_s, rd2_s, imm_ext_s, alu_b_s, alu_res_s, rf_wdata_s;
  logic              rf_we_s;
  logic [REG_AW-1:0] rf_waddr_s;
  alu_op_e           alu_op_s;

  assign op_s        = ir_r[31:26];
  assign funct_s     = ir_r[5:0];
  assign legal_s     = instr_legal(op_s, funct_s);
  assign alu_op_s    = alu_op_of(op_s, funct_s);
  assign imm_ext_s   = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
  assign imem_fire_s = imem_req_r & imem_valid;
  assign dmem_fire_s = dmem_req_r & dmem_valid;

  assign rf_we_s    = (state_r == WB);
  assign rf_waddr_s = (op_s == OP_RTYPE) ? ir_r[11 +: REG_AW] : ir_r[16 +: REG_AW];
  assign rf_wdata_s = (op_s == OP_LW) ? mdr_r : alu_r;

  regfile_2r1w #(.NREG(NREG), .DATA_W(DATA_W), .AW(REG_AW)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (ir_r[21 +: REG_AW]),
    .raddr2 (ir_r[16 +: REG_AW]),
    .rdata1 (rd1_s),
    .rdata2 (rd2_s),
    .we     (rf_we_s),
    .waddr  (rf_waddr_s),
    .wdata  (rf_wdata_s)
  );

  // Shared ALU; the second operand is B for R-type, the immediate otherwise.
  always_comb begin
    alu_b_s = (op_s == OP_RTYPE) ? b_r : imm_r;
    case (alu_op_s)
      ALU_ADD: alu_res_s = a_r + alu_b_s;
      ALU_SUB: alu_res_s = a_r - alu_b_s;
      ALU_AND: alu_res_s = a_r & alu_b_s;
      ALU_OR:  alu_res_s = a_r | alu_b_s;
      ALU_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(alu_b_s))};
      default: alu_res_s = a_r + alu_b_s;
    endcase
  end

  // Next-state and retire decode; retire is high during the final cycle of each instruction.
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      FETCH: begin
        if (imem_fire_s) state_next_s = DECODE;
        else             state_next_s = FETCH;
      end
      DECODE: begin
        if (legal_s) state_next_s = EXEC;
        else         state_next_s = HALT;
      end
      EXEC: begin
        if ((op_s == OP_LW) || (op_s == OP_SW)) begin
          state_next_s = MEM;
        end else if ((op_s == OP_BEQ) || (op_s == OP_J)) begin
          state_next_s = FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = WB;
        end
      end
      MEM: begin
        if (dmem_fire_s && (op_s == OP_LW)) begin
          state_next_s = WB;
        end else if (dmem_fire_s) begin
          state_next_s = FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = MEM;
        end
      end
      WB: begin
        state_next_s = FETCH;
        retire_s     = 1'b1;
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= FETCH;
    else        state_r <= state_next_s;
  end

  // Datapath registers and registered memory requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r         <= 32'd0;
      pc_r         <= {PC_W{1'b0}};
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      imm_r        <= {DATA_W{1'b0}};
      alu_r        <= {DATA_W{1'b0}};
      mdr_r        <= {DATA_W{1'b0}};
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {PC_W{1'b0}};
      dmem_wdata_r <= {DATA_W{1'b0}};
      halted_r     <= 1'b0;
    end else begin
      imem_req_r <= (state_next_s == FETCH);
      case (state_r)
        FETCH: begin
          if (imem_fire_s) begin
            ir_r <= imem_rdata;
            pc_r <= pc_r + PC_ONE;
          end
        end
        DECODE: begin
          if (legal_s) begin
            a_r   <= rd1_s;
            b_r   <= rd2_s;
            imm_r <= imm_ext_s;
          end else begin
            halted_r <= 1'b1;
          end
        end
        EXEC: begin
          case (op_s)
            OP_LW, OP_SW: begin
              dmem_req_r   <= 1'b1;
              dmem_we_r    <= (op_s == OP_SW);
              dmem_addr_r  <= alu_res_s[PC_W-1:0];
              dmem_wdata_r <= b_r;
            end
            OP_BEQ: begin
              if (a_r == b_r) pc_r <= pc_r + imm_r[PC_W-1:0];
            end
            OP_J:    pc_r  <= ir_r[PC_W-1:0];
            default: alu_r <= alu_res_s;
          endcase
        end
        MEM: begin
          if (dmem_fire_s) begin
            mdr_r      <= dmem_rdata;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign pc         = pc_r;
  assign retire     = retire_s;
  assign halted     = halted_r;

endmodule
